// File: rtl/pipeline_pkg.sv
// Shared types for the 5-stage pipeline hazard unit: stage indices, EX forwarding
// encodings and the scoreboard entry carried through EX, MEM and WB.
package pipeline_pkg;

    localparam int unsigned STG_IF  = 0;
    localparam int unsigned STG_ID  = 1;
    localparam int unsigned STG_EX  = 2;
    localparam int unsigned STG_MEM = 3;
    localparam int unsigned STG_WB  = 4;

    // Scoreboard addresses are stored zero-extended to this width; ADDR_W must not exceed it.
    localparam int unsigned SB_ADDR_W = 8;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                 valid;
        logic                 regwrite;
        logic                 memread;
        logic [SB_ADDR_W-1:0] rd;
        logic [SB_ADDR_W-1:0] rs1;
        logic [SB_ADDR_W-1:0] rs2;
        logic                 use_rs1;
        logic                 use_rs2;
    } sb_entry_t;

    // True when the entry will write a nonzero register equal to addr.
    function automatic logic writes_reg(input sb_entry_t e, input logic [SB_ADDR_W-1:0] addr);
        return e.valid & e.regwrite & (e.rd != '0) & (e.rd == addr);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// EX operand forwarding select for one source operand; MEM result wins over WB data.
module fwd_select
    import pipeline_pkg::*;
(
    input  logic [SB_ADDR_W-1:0] src_i,
    input  logic                 use_i,
    input  sb_entry_t            mem_i,
    input  sb_entry_t            wb_i,
    output fwd_sel_t             sel_o
);

    logic unused_entry_bits;
    assign unused_entry_bits = ^{mem_i, wb_i};

    always_comb begin
        sel_o = FWD_RF;
        if (use_i) begin
            if (writes_reg(mem_i, src_i)) begin
                sel_o = FWD_MEM;
            end else if (writes_reg(wb_i, src_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/pipeline-control unit: scoreboard of EX/MEM/WB, forwarding, load-use stall, redirect flush.
// Performance counters are built only when PIPELINE_HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned ADDR_W        = 5,
    parameter int unsigned RESOLVE_STAGE = 3,
    parameter int unsigned CNT_W         = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              redirect,
    output logic              stall,
    output logic              bubble,
    output logic [2:0]        flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam logic [2:0] FLUSH_MASK = (RESOLVE_STAGE == STG_EX) ? 3'b011 : 3'b111;

    sb_entry_t e_ex_q, e_mem_q, e_wb_q;
    sb_entry_t e_ex_d, e_mem_d, e_wb_d;

    logic [SB_ADDR_W-1:0] id_rs1_x, id_rs2_x, id_rd_x;
    logic                 load_use;
    fwd_sel_t             sel_a, sel_b;

    assign id_rs1_x = SB_ADDR_W'(id_rs1);
    assign id_rs2_x = SB_ADDR_W'(id_rs2);
    assign id_rd_x  = SB_ADDR_W'(id_rd);

    // A redirect kills the dependent ID instruction anyway, so it suppresses the stall.
    assign load_use = e_ex_q.valid & e_ex_q.memread & (e_ex_q.rd != '0) &
                      ((id_use_rs1 & (id_rs1_x == e_ex_q.rd)) |
                       (id_use_rs2 & (id_rs2_x == e_ex_q.rd))) &
                      id_valid & ~redirect;

    assign stall  = load_use;
    assign bubble = load_use;
    assign flush  = redirect ? FLUSH_MASK : '0;

    fwd_select u_fwd_a (
        .src_i (e_ex_q.rs1),
        .use_i (e_ex_q.valid & e_ex_q.use_rs1),
        .mem_i (e_mem_q),
        .wb_i  (e_wb_q),
        .sel_o (sel_a)
    );

    fwd_select u_fwd_b (
        .src_i (e_ex_q.rs2),
        .use_i (e_ex_q.valid & e_ex_q.use_rs2),
        .mem_i (e_mem_q),
        .wb_i  (e_wb_q),
        .sel_o (sel_b)
    );

    assign fwd_a = sel_a;
    assign fwd_b = sel_b;

    always_comb begin
        e_ex_d          = '0;
        e_ex_d.valid    = id_valid;
        e_ex_d.regwrite = id_regwrite;
        e_ex_d.memread  = id_memread;
        e_ex_d.rd       = id_rd_x;
        e_ex_d.rs1      = id_rs1_x;
        e_ex_d.rs2      = id_rs2_x;
        e_ex_d.use_rs1  = id_use_rs1;
        e_ex_d.use_rs2  = id_use_rs2;
        if (stall || flush[STG_ID]) begin
            e_ex_d = '0;
        end
        e_mem_d = e_ex_q;
        if (flush[STG_EX] && (RESOLVE_STAGE == STG_MEM)) begin
            e_mem_d = '0;
        end
        e_wb_d = e_mem_q;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            e_ex_q  <= '0;
            e_mem_q <= '0;
            e_wb_q  <= '0;
        end else if (enable) begin
            e_ex_q  <= e_ex_d;
            e_mem_q <= e_mem_d;
            e_wb_q  <= e_wb_d;
        end
    end

`ifdef PIPELINE_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, retire_cnt_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else if (enable) begin
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (redirect) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
            if (e_wb_q.valid) begin
                retire_cnt_q <= retire_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign retire_cnt = retire_cnt_q;
`else
    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
    assign retire_cnt = '0;
`endif

endmodule
